// File: rtl/acc_cpu_pkg.sv
// Shared opcode/state types for the gen2 accumulator core.
// Memory-operand opcodes occupy the low end of the opcode space.
package acc_cpu_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_ST   = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_LD   = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_LDI  = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_JC   = 4'hA,
    OP_CALL = 4'hB,
    OP_RET  = 4'hC,
    OP_NOPD = 4'hD,
    OP_NOPE = 4'hE,
    OP_HLT  = 4'hF
  } opc_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_EXEC,
    S_HALT
  } state_e;

  function automatic logic is_mem_op(input opc_e op);
    return (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: add/sub with carry-borrow, logic ops, loads.
// Zero reflects the result that would be written to acc.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  opc_e              opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  always_comb begin
    result = acc;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: {carry, result} = {1'b0, acc} + {1'b0, operand};
      OP_SUB: {carry, result} = {1'b0, acc} - {1'b0, operand};
      OP_AND: result = acc & operand;
      OP_OR:  result = acc | operand;
      OP_XOR: result = acc ^ operand;
      OP_LD,
      OP_LDI: result = operand;
      default: ;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/acc_cpu_gen2.sv
// Gen2 accumulator core with req/ready memory port and data page.
// Define ACC_CPU_CALL_EN for single-level CALL (B) / RET (C).
module acc_cpu_gen2
  import acc_cpu_pkg::*;
#(
  parameter int          DATA_W   = 8,
  parameter int          ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] acc,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted
);

  localparam int OPD_W = DATA_W - OPC_W;

  state_e            state;
  opc_e              opc;
  logic [OPD_W-1:0]  opd;
  logic [DATA_W-1:0] mreg;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;
  logic              alu_z;
  logic [ADDR_W-1:0] ea;
  logic [ADDR_W-1:0] tgt;
`ifdef ACC_CPU_CALL_EN
  logic [ADDR_W-1:0] link;
`endif

  assign opc = opc_e'(ir[DATA_W-1:DATA_W-OPC_W]);
  assign opd = ir[OPD_W-1:0];
  assign tgt = ADDR_W'(opd);

  // data page sits at the top of memory
  always_comb begin
    ea = '1;
    ea[OPD_W-1:0] = opd;
  end

  assign alu_b = (opc == OP_LDI) ? DATA_W'(opd) : mreg;

  acc_cpu_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .acc    (acc),
    .operand(alu_b),
    .opcode (opc),
    .result (alu_y),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  assign mem_req   = !reset &&
                     (state == S_FETCH || state == S_MEM);
  assign mem_we    = mem_req && (state == S_MEM) &&
                     (opc == OP_ST);
  assign mem_addr  = !mem_req ? '0 :
                     (state == S_MEM) ? ea : pc;
  assign mem_wdata = acc;
  assign halted    = (state == S_HALT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_FETCH;
      pc     <= ADDR_W'(RESET_PC);
      ir     <= '0;
      acc    <= '0;
      mreg   <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
`ifdef ACC_CPU_CALL_EN
      link   <= '0;
`endif
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir    <= mem_rdata;
          pc    <= pc + 1'b1;
          state <= S_DECODE;
        end
        S_DECODE:
          state <= is_mem_op(opc) ? S_MEM : S_EXEC;
        S_MEM: if (mem_ready) begin
          mreg  <= mem_rdata;
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (opc)
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR: begin
              acc    <= alu_y;
              flag_c <= alu_c;
              flag_z <= alu_z;
            end
            OP_LD, OP_LDI: begin
              acc    <= alu_y;
              flag_z <= alu_z;
            end
            OP_JMP: pc <= tgt;
            OP_JZ:  if (flag_z) pc <= tgt;
            OP_JC:  if (flag_c) pc <= tgt;
`ifdef ACC_CPU_CALL_EN
            OP_CALL: begin
              link <= pc;
              pc   <= tgt;
            end
            OP_RET: pc <= link;
`endif
            default: ;
          endcase
          state <= (opc == OP_HLT) ? S_HALT : S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
